// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
// Covers the FSM encoding, the word width and the address-to-index width helper.
package mem_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memState_t;

    // Word-index width for an array of 'depth' words.
    function automatic int indexWidth(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port synchronous word array.
// One write port and one registered read port share the index and the enable.
module sram_1rw
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IW    = indexWidth(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [IW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: the array is deliberately left out of reset so it maps onto plain RAM; contents survive reset.
    always_ff @(posedge clock) begin
        if (en && we)
            mem[idx] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset)
            rdata <= '0;
        else if (en && !we)
            rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// Stalls the pipeline for LAT+1 cycles per aligned access and flags misaligned requests.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              rvalid,
    output logic              mem_stall,
    output logic              misaligned
);

    localparam int         IW        = indexWidth(DEPTH);
    localparam logic [3:0] COUNT_INI = 4'(LAT - 1);

    memState_t         state, nextState;
    logic [3:0]        count;
    logic              opWrite;
    logic [IW-1:0]     idxQ;
    logic [WORD_W-1:0] wdataQ;
    logic              anyReq, aligned, validReq, fire;
    logic              unusedAddrHi;

    assign anyReq       = MemRead | MemWrite;
    assign aligned      = (addr[BYTE_OFF_W-1:0] == '0);
    assign validReq     = anyReq && aligned;
    assign fire         = (state == WAIT) && (count == 4'd0) && !reset;
    assign unusedAddrHi = ^addr[WORD_W-1:IW+BYTE_OFF_W];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    // NOTE: each always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (validReq) nextState = WAIT;
            WAIT:    if (count == 4'd0) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        rvalid    = 1'b0;
        case (state)
            IDLE:    mem_stall = validReq;
            WAIT:    mem_stall = 1'b1;
            DONE:    rvalid    = !opWrite;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= 4'd0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= (state == IDLE) && anyReq && !aligned;
            if (state == IDLE && validReq)
                count <= COUNT_INI;
            else if (state == WAIT && count != 4'd0)
                count <= count - 4'd1;
        end
    end

    // Request capture; MemWrite wins when both request bits are set.
    always_ff @(posedge clock) begin
        if (state == IDLE && validReq) begin
            opWrite <= MemWrite;
            idxQ    <= addr[IW+BYTE_OFF_W-1:BYTE_OFF_W];
            wdataQ  <= wdata;
        end
    end

    sram_1rw #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_sram (
        .clock (clock),
        .reset (reset),
        .en    (fire),
        .we    (opWrite),
        .idx   (idxQ),
        .wdata (wdataQ),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stall timing, load/store data, wrap, misalignment,
// write priority, reset mid-access and back-to-back requests.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] addr, wdata, rdata;
    logic        rvalid, mem_stall, misaligned;

    int total = 0;
    int bad   = 0;

    dmem_responder #(
        .DEPTH (256),
        .LAT   (LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .mem_stall  (mem_stall),
        .misaligned (misaligned)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request and hold it until the DONE cycle, sampling 1 time unit after each falling edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic expValid, input logic [31:0] expData, input string tag);
        int stalls;
        int overlap;
        stalls  = 0;
        overlap = 0;
        @(negedge clock);
        MemRead  = rd;
        MemWrite = wr;
        addr     = a;
        wdata    = d;
        #1;
        check({tag, ".stall_first"}, 32'(mem_stall), 32'd1);
        check({tag, ".rvalid_first"}, 32'(rvalid), 32'd0);
        while (mem_stall && stalls < 20) begin
            stalls++;
            if (rvalid) overlap++;
            @(negedge clock);
            #1;
        end
        check({tag, ".stall_cycles"}, 32'(stalls), 32'(LAT + 1));
        check({tag, ".rvalid_done"}, 32'(rvalid), 32'(expValid));
        if (expValid)
            check({tag, ".rdata"}, rdata, expData);
        check({tag, ".overlap"}, 32'(overlap), 32'd0);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        reset    = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        addr     = '0;
        wdata    = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst.rdata", rdata, 32'd0);
        check("rst.rvalid", 32'(rvalid), 32'd0);
        check("rst.stall", 32'(mem_stall), 32'd0);
        check("rst.misaligned", 32'(misaligned), 32'd0);

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "sw10");
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, "lw10");

        // 0x404 wraps onto word index 1 with DEPTH=256.
        access(1'b0, 1'b1, 32'h4, 32'h11112222, 1'b0, 32'h0, "sw04");
        access(1'b1, 1'b0, 32'h404, 32'h0, 1'b1, 32'h11112222, "lw404");

        @(negedge clock);
        MemRead = 1'b1;
        addr    = 32'h13;
        #1;
        check("mis.stall_req", 32'(mem_stall), 32'd0);
        check("mis.pulse_req", 32'(misaligned), 32'd0);
        @(negedge clock);
        MemRead = 1'b0;
        #1;
        check("mis.pulse", 32'(misaligned), 32'd1);
        check("mis.stall_pulse", 32'(mem_stall), 32'd0);
        @(negedge clock);
        #1;
        check("mis.pulse_end", 32'(misaligned), 32'd0);
        check("mis.stall_end", 32'(mem_stall), 32'd0);
        check("mis.rdata_kept", rdata, 32'h11112222);

        access(1'b1, 1'b1, 32'h0, 32'h55, 1'b0, 32'h0, "both");

        access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, "sw20");
        @(negedge clock);
        MemWrite = 1'b1;
        addr     = 32'h20;
        wdata    = 32'h1234;
        #1;
        check("rmid.stall_req", 32'(mem_stall), 32'd1);
        @(negedge clock);
        #1;
        check("rmid.stall_wait1", 32'(mem_stall), 32'd1);
        @(negedge clock);
        reset    = 1'b1;
        MemWrite = 1'b0;
        #1;
        check("rmid.stall_wait2", 32'(mem_stall), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rmid.stall_after", 32'(mem_stall), 32'd0);
        check("rmid.rdata_after", rdata, 32'd0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D, "lw20");

        access(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h55, "b2b0");
        access(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 32'h11112222, "b2b4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the MEM stage of the 5-stage MIPS32 pipeline. It answers the `MemRead`/`MemWrite` requests that the main decoder generates and the EX/MEM register carries. When an access takes more than one cycle, it drives `mem_stall` back to the pipeline. The hazard unit merges `mem_stall` into its PC/IF-ID/ID-EX/EX-MEM write-enables. This makes the block the memory-side end of the request/stall interface, replacing the ideal single-cycle data memory.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words; power of two.
- `LAT`, 2: wait cycles per access; legal range 1..15.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemRead`  in  1  load request from EX/MEM.
- `MemWrite`  in  1  store request from EX/MEM.
- `addr`  in  32  byte address; ALU result.
- `wdata`  in  32  store data; forwarded rt value.
- `rdata`  out  32  load data; registered.
- `rvalid`  out  1  `rdata` valid this cycle.
- `mem_stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble MEM/WB.
- `misaligned`  out  1  one-cycle error pulse; no access performed.

## Operation
- Word index is `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH`.
- A request is valid when `MemRead | MemWrite` and `addr[1:0]==0`. If both request bits are set, `MemWrite` wins and `rvalid` stays 0.
- The FSM has three states: IDLE, WAIT, DONE.
- IDLE
  - Valid request: latch op, index and `wdata`; load the counter with `LAT-1`; go to WAIT.
  - `mem_stall` = valid request, decoded combinationally so the stall is visible in the request cycle.
  - Misaligned request: `misaligned`=1 in the following cycle; no stall; stay in IDLE.
- WAIT
  - `mem_stall`=1; the counter decrements each cycle.
  - On the edge where the counter is 0:
    - Store: array[index] <= latched wdata.
    - Load: `rdata` <= array[index].
    - Go to DONE.
- DONE
  - `mem_stall`=0; `rvalid`=1 for a load. The pipeline advances on this edge.
  - Next state is IDLE unconditionally. A new request becomes visible only after EX/MEM updates.
- The latched request is used for the whole access; input changes during WAIT are ignored.
- `rdata` holds its last value until the next load completes.

## Timing
- A request first presented in cycle 0:
  - `mem_stall` is high for cycles 0..LAT, i.e. LAT+1 cycles.
  - DONE is in cycle LAT+1; total occupancy is LAT+2 cycles.
- Load data appears in cycle LAT+1, registered, when MEM/WB captures it.
- Store is committed at the end of cycle LAT; a load in the same index issued afterwards returns the new data.
- Back-to-back requests: the second request is seen in the cycle after DONE.
- Reset values: state=IDLE, counter=0, `rdata`=0, `rvalid`=0, `mem_stall`=0, `misaligned`=0.
- Reset mid-access returns to IDLE and drops `mem_stall` the next cycle. A pending store is discarded. Array contents are not cleared.
- `reset` wins over any simultaneous request.

## Structure
- Shared package `mem_pkg`:
  - FSM state encoding (2 bits: IDLE=0, WAIT=1, DONE=2).
  - Word width 32.
  - Address-to-index helper width constant.
- Sub-module `sram_1rw`: synchronous single-port array with one write port and one registered read port, sharing index and enable. It is instantiated once. The FSM and counter stay in `dmem_responder`.
- `mem_stall` is ORed with the load-use stall inside the hazard unit, outside this block.

## Test plan
- Reset, then `LAT=2`, SW addr 0x10 wdata 0xDEADBEEF:
  - `mem_stall` high exactly 3 cycles, then low.
  - A subsequent LW 0x10 yields `rdata`=0xDEADBEEF with `rvalid`=1 in its DONE cycle.
- LW addr 0x404 with `DEPTH`=256 returns the word at index 1; wrap check on the value previously stored at 0x4.
- LW addr 0x13 gives a `misaligned` pulse for 1 cycle, `mem_stall` never high, and `rdata` unchanged.
- `MemRead` and `MemWrite` both high with wdata 0x55: the write is performed, `rvalid` stays 0, and a later LW returns 0x55.
- Reset asserted in the second WAIT cycle of an SW of 0x1234 to 0x20:
  - `mem_stall` is 0 the next cycle.
  - A later LW 0x20 returns the old contents, not 0x1234.
- Back-to-back LW 0x0 then LW 0x4: the second stall starts the cycle after DONE, and there is no cycle in which both `rvalid` and `mem_stall` are high.
